pipe_ctrl: RTL and testbench

Central pipeline controller for the five-stage MIPS core: it owns the `stall` bus consumed by IF, ID, EX, MEM and WB and resolves all read-after-write hazards for the instruction in ID. A three-entry destination scoreboard mirrors the EX/MEM/WB pipeline registers. From it the block derives per-operand forwarding selects and load-use stalls, then merges those with multi-cycle stall requests from EX and MEM. It sits beside ID and is the only driver of `stall`.

---
 rtl/pipe_ctrl_pkg.sv | 48 ++++
 rtl/pipe_ctrl_fwd_match.sv | 30 +++
 rtl/pipe_ctrl.sv | 106 ++++++++++
 tb/tb_pipe_ctrl.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/pipe_ctrl_pkg.sv
// Shared types and constants for the pipeline controller: stall bus encoding,
// forwarding selects and the destination scoreboard entry.
package pipe_ctrl_pkg;

  localparam logic STOP    = 1'b1;
  localparam logic NO_STOP = 1'b0;

  typedef logic [5:0] stall_bus_t;

  localparam int STG_ID  = 2;
  localparam int STG_EX  = 3;
  localparam int STG_MEM = 4;
  localparam int STG_WB  = 5;

  localparam stall_bus_t STALL_NONE = 6'b000000;
  localparam stall_bus_t STALL_ID   = 6'b000111;
  localparam stall_bus_t STALL_EX   = 6'b001111;
  localparam stall_bus_t STALL_MEM  = 6'b011111;

  typedef enum logic [1:0] {
    FWD_RF  = 2'd0,
    FWD_EX  = 2'd1,
    FWD_MEM = 2'd2,
    FWD_WB  = 2'd3
  } fwd_sel_e;

  typedef struct packed {
    logic       we;
    logic [4:0] waddr;
    logic       is_load;
  } sb_entry_t;

  localparam sb_entry_t SB_EMPTY = '0;

  function automatic logic hazard(input logic used, input logic [4:0] addr,
                                  input sb_entry_t e);
    return used && e.we && (e.waddr == addr) && (addr != 5'd0);
  endfunction

  // A stalled stage keeps its entry; a stage whose source is stalled takes a bubble.
  function automatic sb_entry_t sb_advance(input sb_entry_t cur, input sb_entry_t src,
                                           input logic stall_self, input logic stall_src);
    if (stall_self == STOP) return cur;
    else if (stall_src == NO_STOP) return src;
    else return SB_EMPTY;
  endfunction

endpackage

// File: rtl/pipe_ctrl_fwd_match.sv
// Matches one ID source operand against the EX/MEM/WB scoreboard entries and
// picks the youngest producer.
module pipe_ctrl_fwd_match
  import pipe_ctrl_pkg::*;
(
  input  logic       used_i,
  input  logic [4:0] addr_i,
  input  sb_entry_t  ex_i,
  input  sb_entry_t  mem_i,
  input  sb_entry_t  wb_i,
  output logic [2:0] hit_o,
  output fwd_sel_e   sel_o
);

  logic unused_ld;
  assign unused_ld = ^{ex_i.is_load, mem_i.is_load, wb_i.is_load};

  // hit_o bit 0 = EX, 1 = MEM, 2 = WB
  assign hit_o = {hazard(used_i, addr_i, wb_i),
                  hazard(used_i, addr_i, mem_i),
                  hazard(used_i, addr_i, ex_i)};

  always_comb begin
    sel_o = FWD_RF;
    if (hit_o[0])      sel_o = FWD_EX;
    else if (hit_o[1]) sel_o = FWD_MEM;
    else if (hit_o[2]) sel_o = FWD_WB;
  end

endmodule

// File: rtl/pipe_ctrl.sv
// Pipeline controller: scoreboard-based hazard detection, forwarding selects and
// stall merge. Define PIPE_CTRL_FWD_EN to enable forwarding; otherwise every hazard stalls ID.
module pipe_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int STALL_W = 6
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               id_valid,
  input  logic [4:0]         id_rs,
  input  logic [4:0]         id_rt,
  input  logic               id_rs_used,
  input  logic               id_rt_used,
  input  logic               id_rf_we,
  input  logic [4:0]         id_rf_waddr,
  input  logic               id_is_load,
  input  logic               ex_stallreq,
  input  logic               mem_stallreq,
  output logic [STALL_W-1:0] stall,
  output logic [1:0]         fwd_sel_a,
  output logic [1:0]         fwd_sel_b,
  output logic               load_use
);

  sb_entry_t  sb_ex_q, sb_mem_q, sb_wb_q;
  sb_entry_t  sb_ex_d, sb_mem_d, sb_wb_d;
  sb_entry_t  id_entry;
  logic [2:0] hit_a, hit_b;
  fwd_sel_e   sel_a, sel_b;
  logic       data_haz;
  stall_bus_t stall_pat;

  pipe_ctrl_fwd_match u_match_rs (
    .used_i (id_rs_used),
    .addr_i (id_rs),
    .ex_i   (sb_ex_q),
    .mem_i  (sb_mem_q),
    .wb_i   (sb_wb_q),
    .hit_o  (hit_a),
    .sel_o  (sel_a)
  );

  pipe_ctrl_fwd_match u_match_rt (
    .used_i (id_rt_used),
    .addr_i (id_rt),
    .ex_i   (sb_ex_q),
    .mem_i  (sb_mem_q),
    .wb_i   (sb_wb_q),
    .hit_o  (hit_b),
    .sel_o  (sel_b)
  );

`ifdef PIPE_CTRL_FWD_EN
  logic unused_hit;
  assign unused_hit = ^{hit_a[2:1], hit_b[2:1]};

  // Only a load still in EX cannot be forwarded; its data appears from MEM onward.
  assign data_haz  = id_valid && sb_ex_q.is_load && (hit_a[0] || hit_b[0]);
  assign fwd_sel_a = id_valid ? sel_a : FWD_RF;
  assign fwd_sel_b = id_valid ? sel_b : FWD_RF;
`else
  logic unused_sel;
  assign unused_sel = ^{sel_a, sel_b};

  assign data_haz  = id_valid && ((|hit_a) || (|hit_b));
  assign fwd_sel_a = FWD_RF;
  assign fwd_sel_b = FWD_RF;
`endif

  always_comb begin
    stall_pat = STALL_NONE;
    if (mem_stallreq)     stall_pat = STALL_MEM;
    else if (ex_stallreq) stall_pat = STALL_EX;
    else if (data_haz)    stall_pat = STALL_ID;
  end

  assign stall    = STALL_W'(stall_pat);
  assign load_use = data_haz && !mem_stallreq && !ex_stallreq;

  always_comb begin
    id_entry = SB_EMPTY;
    if (id_valid) begin
      id_entry.we      = id_rf_we;
      id_entry.waddr   = id_rf_waddr;
      id_entry.is_load = id_is_load;
    end
  end

  assign sb_ex_d  = sb_advance(sb_ex_q,  id_entry, stall_pat[STG_EX],  stall_pat[STG_ID]);
  assign sb_mem_d = sb_advance(sb_mem_q, sb_ex_q,  stall_pat[STG_MEM], stall_pat[STG_EX]);
  assign sb_wb_d  = sb_advance(sb_wb_q,  sb_mem_q, stall_pat[STG_WB],  stall_pat[STG_MEM]);

  always_ff @(posedge clk) begin
    if (rst) begin
      sb_ex_q  <= SB_EMPTY;
      sb_mem_q <= SB_EMPTY;
      sb_wb_q  <= SB_EMPTY;
    end else begin
      sb_ex_q  <= sb_ex_d;
      sb_mem_q <= sb_mem_d;
      sb_wb_q  <= sb_wb_d;
    end
  end

endmodule

// File: tb/tb_pipe_ctrl.sv
// Directed bench for pipe_ctrl; expectations follow the PIPE_CTRL_FWD_EN setting.
module tb_pipe_ctrl;

`ifdef PIPE_CTRL_FWD_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst;
  logic       id_valid;
  logic [4:0] id_rs, id_rt;
  logic       id_rs_used, id_rt_used;
  logic       id_rf_we;
  logic [4:0] id_rf_waddr;
  logic       id_is_load;
  logic       ex_stallreq, mem_stallreq;
  logic [5:0] stall;
  logic [1:0] fwd_sel_a, fwd_sel_b;
  logic       load_use;

  int total  = 0;
  int passed = 0;

  pipe_ctrl #(.STALL_W(6)) dut (
    .clk          (clk),
    .rst          (rst),
    .id_valid     (id_valid),
    .id_rs        (id_rs),
    .id_rt        (id_rt),
    .id_rs_used   (id_rs_used),
    .id_rt_used   (id_rt_used),
    .id_rf_we     (id_rf_we),
    .id_rf_waddr  (id_rf_waddr),
    .id_is_load   (id_is_load),
    .ex_stallreq  (ex_stallreq),
    .mem_stallreq (mem_stallreq),
    .stall        (stall),
    .fwd_sel_a    (fwd_sel_a),
    .fwd_sel_b    (fwd_sel_b),
    .load_use     (load_use)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic settle;
    #3;
  endtask

  task automatic idle;
    id_valid = 0; id_rs = 0; id_rt = 0; id_rs_used = 0; id_rt_used = 0;
    id_rf_we = 0; id_rf_waddr = 0; id_is_load = 0;
  endtask

  task automatic id_set(input logic [4:0] rs, input logic [4:0] rt, input logic rsu,
                        input logic rtu, input logic we, input logic [4:0] wa,
                        input logic ld);
    id_valid = 1; id_rs = rs; id_rt = rt; id_rs_used = rsu; id_rt_used = rtu;
    id_rf_we = we; id_rf_waddr = wa; id_is_load = ld;
  endtask

  task automatic drain;
    idle();
    repeat (3) begin
      settle();
      chk("drain_stall", stall, 6'b000000);
      tick();
    end
  endtask

  // addiu $1,$3 ; n nops ; consumer of $1 through rs or rt
  task automatic dep_pair(input int n, input bit use_rt);
    logic [1:0] exp_sel;
    exp_sel = FWD ? 2'(n + 1) : 2'd0;
    id_set(5'd3, 5'd0, 1, 0, 1, 5'd1, 0);
    settle();
    chk("dep_producer_stall", stall, 6'b000000);
    tick();
    repeat (n) begin
      id_set(5'd0, 5'd0, 0, 0, 0, 5'd0, 0);
      tick();
    end
    if (use_rt) id_set(5'd2, 5'd1, 1, 1, 1, 5'd4, 0);
    else        id_set(5'd1, 5'd0, 1, 0, 1, 5'd4, 0);
    settle();
    for (int i = 0; i < (FWD ? 0 : 3 - n); i++) begin
      chk("dep_stall_id", stall, 6'b000111);
      chk("dep_load_use", load_use, 1'b1);
      tick();
      settle();
    end
    chk("dep_release_stall", stall, 6'b000000);
    chk("dep_release_lu", load_use, 1'b0);
    chk("dep_fwd_a", fwd_sel_a, use_rt ? 2'd0 : exp_sel);
    chk("dep_fwd_b", fwd_sel_b, use_rt ? exp_sel : 2'd0);
    tick();
    drain();
  endtask

  // lw $5,($29) ; addiu $6,$5 with optional MEM/EX stall requests while the hazard is pending
  task automatic lw_dep(input int mem_cycles, input int ex_cycles);
    id_set(5'd29, 5'd0, 1, 0, 1, 5'd5, 1);
    settle();
    chk("lw_issue_stall", stall, 6'b000000);
    tick();
    id_set(5'd5, 5'd0, 1, 0, 1, 5'd6, 0);
    for (int i = 0; i < mem_cycles; i++) begin
      mem_stallreq = 1;
      settle();
      chk("lw_memreq_stall", stall, 6'b011111);
      chk("lw_memreq_lu", load_use, 1'b0);
      tick();
    end
    mem_stallreq = 0;
    for (int i = 0; i < ex_cycles; i++) begin
      ex_stallreq = 1;
      settle();
      chk("lw_exreq_stall", stall, 6'b001111);
      chk("lw_exreq_lu", load_use, 1'b0);
      tick();
    end
    ex_stallreq = 0;
    chk("lw_sb_ex_held", dut.sb_ex_q, 7'b1_00101_1);
    settle();
    for (int i = 0; i < (FWD ? 1 : 3); i++) begin
      chk("lw_stall_id", stall, 6'b000111);
      chk("lw_load_use", load_use, 1'b1);
      tick();
      settle();
    end
    chk("lw_release_stall", stall, 6'b000000);
    chk("lw_release_lu", load_use, 1'b0);
    chk("lw_fwd_a", fwd_sel_a, FWD ? 2'd2 : 2'd0);
    chk("lw_sb_ex_bubble", dut.sb_ex_q, 7'b0);
    tick();
    drain();
  endtask

  initial begin
    rst = 1; ex_stallreq = 0; mem_stallreq = 0;
    idle();
    tick();
    tick();
    rst = 0;
    id_set(5'd1, 5'd2, 1, 1, 1, 5'd3, 1);
    settle();
    chk("reset_stall", stall, 6'b000000);
    chk("reset_fwd_a", fwd_sel_a, 2'd0);
    chk("reset_fwd_b", fwd_sel_b, 2'd0);
    chk("reset_lu", load_use, 1'b0);
    tick();
    drain();

    // independent stream: ori $1,$0 ; addiu $2,$3
    id_set(5'd0, 5'd0, 1, 0, 1, 5'd1, 0);
    settle();
    chk("indep_ori_stall", stall, 6'b000000);
    chk("indep_ori_fwd", fwd_sel_a, 2'd0);
    tick();
    id_set(5'd3, 5'd0, 1, 0, 1, 5'd2, 0);
    settle();
    chk("indep_addiu_stall", stall, 6'b000000);
    chk("indep_addiu_fwd", fwd_sel_a, 2'd0);
    tick();
    drain();

    dep_pair(0, 0);
    dep_pair(1, 0);
    dep_pair(2, 0);
    dep_pair(0, 1);
    dep_pair(2, 1);

    // $0 written then read: never a hazard
    id_set(5'd0, 5'd0, 0, 0, 1, 5'd0, 0);
    tick();
    id_set(5'd0, 5'd0, 1, 1, 1, 5'd7, 0);
    settle();
    chk("zero_stall", stall, 6'b000000);
    chk("zero_fwd_a", fwd_sel_a, 2'd0);
    chk("zero_fwd_b", fwd_sel_b, 2'd0);
    chk("zero_lu", load_use, 1'b0);
    tick();
    drain();

    lw_dep(0, 0);
    lw_dep(3, 0);
    lw_dep(0, 1);

    // reset while EX is stalled with a full scoreboard
    id_set(5'd3, 5'd0, 1, 0, 1, 5'd8, 0);
    tick();
    id_set(5'd3, 5'd0, 1, 0, 1, 5'd9, 0);
    tick();
    id_set(5'd9, 5'd8, 1, 1, 1, 5'd10, 0);
    ex_stallreq = 1;
    settle();
    chk("rst_mid_exreq_stall", stall, 6'b001111);
    rst = 1;
    tick();
    rst = 0;
    ex_stallreq = 0;
    settle();
    chk("rst_mid_stall", stall, 6'b000000);
    chk("rst_mid_fwd_a", fwd_sel_a, 2'd0);
    chk("rst_mid_fwd_b", fwd_sel_b, 2'd0);
    chk("rst_mid_lu", load_use, 1'b0);
    tick();
    idle();
    tick();
    dep_pair(0, 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
